// File: rtl/ssi_entry_display_if.sv
// Bundles the entry controls, entered value and scan outputs of
// ssi_entry_display. "master" drives the debounced controls and observes the
// outputs; "slave" is the display block itself.
//   enter, clear   : single-cycle pulses
//   switches       : hex digit to shift in
//   error          : level, selects the blinking dash pattern
//   numb/mask/count/full : entered value and its occupancy
//   anodes/cathodes: active-low digit select / segments {dp,g,f,e,d,c,b,a}
interface ssi_entry_display_if #(
  parameter int unsigned DIGITS = 8
);
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic                  enter;
  logic                  clear;
  logic [3:0]            switches;
  logic                  error;
  logic [4*DIGITS-1:0]   numb;
  logic [DIGITS-1:0]     mask;
  logic [CW-1:0]         count;
  logic                  full;
  logic [DIGITS-1:0]     anodes;
  logic [7:0]            cathodes;

  modport master (
    output enter, clear, switches, error,
    input  numb, mask, count, full, anodes, cathodes
  );

  modport slave (
    input  enter, clear, switches, error,
    output numb, mask, count, full, anodes, cathodes
  );
endinterface

// File: rtl/ssi_entry_display.sv
// Hex entry shift register merged with a multiplexed seven-segment scanner.
// Digits are shifted in on enter (newest in numb[3:0]) until DIGITS are held;
// clear erases everything and beats a simultaneous enter. The scanner drives
// one digit for SCAN_DIV cycles at a time; a blink phase toggling every
// BLINK_FRAMES frames animates the entry cursor and the error dash pattern.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : ssi_entry_display_if.slave (controls in, value and display out)
module ssi_entry_display #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input logic                clk,
  input logic                rst,
  ssi_entry_display_if.slave bus
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [4*DIGITS-1:0] numb_q, numb_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full;

  logic [SW-1:0]       scan_q;
  logic [IW-1:0]       idx_q;
  logic [FW-1:0]       frame_q;
  logic                blink_q;
  logic                scan_wrap, idx_wrap, frame_wrap;

  logic [DIGITS-1:0]   anodes_q, anodes_d;
  logic [7:0]          cathodes_q, cathodes_d;
  logic [DIGITS-1:0]   sel;
  logic [3:0]          nib;

  function automatic logic [7:0] hex_seg(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign full = (count_q == CW'(DIGITS));

  // Entry register: clear has priority, enter is ignored once full.
  always_comb begin
    numb_d  = numb_q;
    mask_d  = mask_q;
    count_d = count_q;
    if (bus.clear) begin
      numb_d  = '0;
      mask_d  = '0;
      count_d = '0;
    end else if (bus.enter && !full) begin
      numb_d  = {numb_q[4*DIGITS-5:0], bus.switches};
      mask_d  = {mask_q[DIGITS-2:0], 1'b1};
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      numb_q  <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      numb_q  <= numb_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  assign scan_wrap  = (scan_q == SW'(SCAN_DIV - 1));
  assign idx_wrap   = (idx_q == IW'(DIGITS - 1));
  assign frame_wrap = (frame_q == FW'(BLINK_FRAMES - 1));

  // Scan prescaler -> digit index -> frame counter -> blink phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
    end else if (scan_wrap) begin
      scan_q <= '0;
      idx_q  <= idx_wrap ? '0 : idx_q + 1'b1;
      if (idx_wrap) begin
        frame_q <= frame_wrap ? '0 : frame_q + 1'b1;
        if (frame_wrap) blink_q <= ~blink_q;
      end
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  // Display recomputed every cycle from the current slot; registered so the
  // board pins see glitch-free, one-hot-low anodes.
  always_comb begin
    anodes_d   = '1;
    cathodes_d = '1;
    sel        = ~(DIGITS'(1) << idx_q);
    nib        = numb_q[{idx_q, 2'b00} +: 4];
    if (bus.error) begin
      if (blink_q) begin
        anodes_d   = sel;
        cathodes_d = 8'hBF;
      end
    end else if (mask_q[idx_q]) begin
      anodes_d   = sel;
      cathodes_d = hex_seg(nib);
    end else if ((CW'(idx_q) == count_q) && !full) begin
      if (blink_q) begin
        anodes_d   = sel;
        cathodes_d = 8'hF7;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anodes_q   <= '1;
      cathodes_q <= '1;
    end else begin
      anodes_q   <= anodes_d;
      cathodes_q <= cathodes_d;
    end
  end

  assign bus.numb     = numb_q;
  assign bus.mask     = mask_q;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.anodes   = anodes_q;
  assign bus.cathodes = cathodes_q;

endmodule

// File: tb/tb_ssi_entry_display.sv
module tb_ssi_entry_display;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  ssi_entry_display_if #(.DIGITS(4)) bus ();

  ssi_entry_display #(
    .DIGITS(4),
    .SCAN_DIV(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Edges since reset release. With SCAN_DIV=4, DIGITS=4, BLINK_FRAMES=2:
  // after n edges index = (n/4)%4 and blink = (n/32)%2; the registered
  // display seen after n edges shows the slot state after n-1 edges.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic enter_digit(input logic [3:0] v, input logic clr);
    @(negedge clk);
    bus.enter    = 1'b1;
    bus.clear    = clr;
    bus.switches = v;
    @(negedge clk);
    bus.enter    = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  // Advance to a negedge where the display shows slot idx (and phase ph,
  // unless ph < 0). Bounded; an expired bound is a failed comparison.
  task automatic wait_slot(input int idx, input int ph, input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (cyc >= 1 && ((cyc - 1) / 4) % 4 == idx &&
          (ph < 0 || ((cyc - 1) / 32) % 2 == ph))
        found = 1'b1;
    end
    check({tag, "_reach"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    bus.enter    = 1'b0;
    bus.clear    = 1'b0;
    bus.switches = 4'h0;
    bus.error    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_numb",     {16'd0, bus.numb},     32'h0000);
    check("rst_mask",     {28'd0, bus.mask},     32'h0);
    check("rst_count",    {29'd0, bus.count},    32'd0);
    check("rst_full",     {31'd0, bus.full},     32'd0);
    check("rst_anodes",   {28'd0, bus.anodes},   32'hF);
    check("rst_cathodes", {24'd0, bus.cathodes}, 32'hFF);
    rst = 1'b1;

    // Fill all four digits
    enter_digit(4'h1, 1'b0);
    enter_digit(4'h2, 1'b0);
    enter_digit(4'h3, 1'b0);
    check("full_at3",     {31'd0, bus.full},     32'd0);
    check("count_at3",    {29'd0, bus.count},    32'd3);
    enter_digit(4'h4, 1'b0);
    check("fill_numb",    {16'd0, bus.numb},     32'h1234);
    check("fill_mask",    {28'd0, bus.mask},     32'hF);
    check("fill_count",   {29'd0, bus.count},    32'd4);
    check("fill_full",    {31'd0, bus.full},     32'd1);
    wait_slot(0, -1, "s0");
    check("s0_anodes",    {28'd0, bus.anodes},   32'hE);
    check("s0_cathodes",  {24'd0, bus.cathodes}, 32'h99);
    wait_slot(3, -1, "s3");
    check("s3_anodes",    {28'd0, bus.anodes},   32'h7);
    check("s3_cathodes",  {24'd0, bus.cathodes}, 32'hF9);

    // Enter while full is ignored
    enter_digit(4'hA, 1'b0);
    check("ovf_numb",     {16'd0, bus.numb},     32'h1234);
    check("ovf_count",    {29'd0, bus.count},    32'd4);
    check("ovf_mask",     {28'd0, bus.mask},     32'hF);

    // Clear, enter A, then clear+enter together: clear wins
    clear_pulse();
    enter_digit(4'hA, 1'b0);
    check("a_numb",       {16'd0, bus.numb},     32'h000A);
    check("a_count",      {29'd0, bus.count},    32'd1);
    enter_digit(4'h5, 1'b1);
    check("ce_numb",      {16'd0, bus.numb},     32'h0000);
    check("ce_mask",      {28'd0, bus.mask},     32'h0);
    check("ce_count",     {29'd0, bus.count},    32'd0);

    // One digit C: steady digit, blinking cursor in slot 1, rest blank
    enter_digit(4'hC, 1'b0);
    check("c_numb",       {16'd0, bus.numb},     32'h000C);
    check("c_mask",       {28'd0, bus.mask},     32'h1);
    wait_slot(1, 1, "cur1");
    check("cur1_anodes",  {28'd0, bus.anodes},   32'hD);
    check("cur1_cathodes",{24'd0, bus.cathodes}, 32'hF7);
    wait_slot(0, 1, "c0p1");
    check("c0p1_cathodes",{24'd0, bus.cathodes}, 32'hC6);
    check("c0p1_anodes",  {28'd0, bus.anodes},   32'hE);
    wait_slot(1, 0, "cur0");
    check("cur0_anodes",  {28'd0, bus.anodes},   32'hF);
    wait_slot(0, 0, "c0p0");
    check("c0p0_cathodes",{24'd0, bus.cathodes}, 32'hC6);
    wait_slot(2, -1, "blk2");
    check("blk2_anodes",  {28'd0, bus.anodes},   32'hF);
    check("blk2_cathodes",{24'd0, bus.cathodes}, 32'hFF);
    wait_slot(3, -1, "blk3");
    check("blk3_anodes",  {28'd0, bus.anodes},   32'hF);
    check("blk3_cathodes",{24'd0, bus.cathodes}, 32'hFF);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("onehot", {31'd0, ($countones(~bus.anodes) <= 1)}, 32'd1);
    end

    // Error pattern; entry still accepted while error is high
    clear_pulse();
    bus.error = 1'b1;
    enter_digit(4'h1, 1'b0);
    enter_digit(4'h2, 1'b0);
    enter_digit(4'h3, 1'b0);
    enter_digit(4'h4, 1'b0);
    check("err_numb",     {16'd0, bus.numb},     32'h1234);
    check("err_count",    {29'd0, bus.count},    32'd4);
    wait_slot(2, 1, "e2p1");
    check("e2p1_anodes",  {28'd0, bus.anodes},   32'hB);
    check("e2p1_cathodes",{24'd0, bus.cathodes}, 32'hBF);
    wait_slot(0, 1, "e0p1");
    check("e0p1_anodes",  {28'd0, bus.anodes},   32'hE);
    check("e0p1_cathodes",{24'd0, bus.cathodes}, 32'hBF);
    wait_slot(1, 0, "e1p0");
    check("e1p0_anodes",  {28'd0, bus.anodes},   32'hF);
    @(negedge clk);
    bus.error = 1'b0;
    wait_slot(1, -1, "ok1");
    check("ok1_anodes",   {28'd0, bus.anodes},   32'hD);
    check("ok1_cathodes", {24'd0, bus.cathodes}, 32'hB0);
    wait_slot(2, -1, "ok2");
    check("ok2_cathodes", {24'd0, bus.cathodes}, 32'hA4);

    // Asynchronous reset mid-frame
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_numb",    {16'd0, bus.numb},     32'h0000);
    check("arst_mask",    {28'd0, bus.mask},     32'h0);
    check("arst_count",   {29'd0, bus.count},    32'd0);
    check("arst_full",    {31'd0, bus.full},     32'd0);
    check("arst_anodes",  {28'd0, bus.anodes},   32'hF);
    check("arst_cathodes",{24'd0, bus.cathodes}, 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    enter_digit(4'h7, 1'b0);
    wait_slot(0, -1, "post0");
    check("post0_cathodes",{24'd0, bus.cathodes}, 32'hF8);
    check("post0_anodes", {28'd0, bus.anodes},   32'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssi_entry_display.md
Name: ssi_entry_display

Overview:
Parametrised successor of the switch-entry / seven-segment subsystem. It merges the hex entry shift register and the segment scan controller into one block, with a generic digit count and an internal scan prescaler. It adds a blinking entry cursor, a full flag and a blinking error pattern. It sits after the enter/reset debouncers and drives the board anodes/cathodes directly.

Parameters:
DIGITS, 8, number of hex digits held and displayed; legal range 2..16
SCAN_DIV, 1000, clk cycles each digit is driven before the scan advances; minimum 2
BLINK_FRAMES, 64, complete scan frames (DIGITS digit slots each) per blink-phase toggle; minimum 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enter  in  1  single-cycle pulse (debounced): shift switches in as a new digit
clear  in  1  single-cycle pulse (debounced): erase all entered digits
switches  in  4  hex value of the digit to enter
error  in  1  level: show the error pattern instead of the number
numb  out  4*DIGITS  entered value; numb[3:0] = most recent digit
mask  out  DIGITS  bit i = 1 when digit i holds an entered value
count  out  $clog2(DIGITS+1)  number of digits entered
full  out  1  count == DIGITS
anodes  out  DIGITS  active-low digit select
cathodes  out  8  active-low segments {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (rst=0, asynchronous): numb=0, mask=0, count=0, full=0, anodes=all 1, cathodes=8'hFF, scan counter=0, digit index=0, frame counter=0, blink phase=0.
- Entry, on the clk edge where enter=1 and full=0: numb <= {numb[4*DIGITS-5:0], switches}; mask <= {mask[DIGITS-2:0],1'b1}; count++. Visible the next cycle.
- enter while full=1: ignored; numb, mask and count hold.
- clear=1: numb, mask and count go to 0 on that edge. clear and enter in the same cycle: clear wins and the digit is discarded.
- full is combinational from count. After the DIGITS-th entry, full goes to 1 on the same edge that count reaches DIGITS.
- error has no effect on entry. Pulses are still accepted while error=1.
- Scan counter: 0..SCAN_DIV-1. At wrap, digit index increments; index DIGITS-1 wraps to 0.
- A frame ends when the index wraps to 0. Frame counter: 0..BLINK_FRAMES-1; at its wrap, blink phase toggles.
- Display outputs are registered. Each is updated on the edge after an index change, and is also refreshed every cycle. For current index i:
  - error=1: blink phase 1 -> anodes bit i low, cathodes=8'hBF (dash). Blink phase 0 -> anodes all 1.
  - else mask[i]=1: anodes bit i low; cathodes = hex pattern of numb[4i+3:4i].
  - else i==count and full=0 (cursor slot): blink phase 1 -> anodes bit i low, cathodes=8'hF7 (underscore). Blink phase 0 -> anodes all 1.
  - else: anodes all 1, cathodes=8'hFF.
- Hex patterns, dp always off:

| digit | cathodes | digit | cathodes |
|---|---|---|---|
| 0 | C0 | 8 | 80 |
| 1 | F9 | 9 | 90 |
| 2 | A4 | A | 88 |
| 3 | B0 | B | 83 |
| 4 | 99 | C | C6 |
| 5 | 92 | D | A1 |
| 6 | 82 | E | 86 |
| 7 | F8 | F | 8E |

- At most one anode bit is low in any cycle.
- Reset mid-scan or mid-entry returns everything to the reset values. Scan restarts at index 0.

Test Plan:
- Reset, DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2 -> numb=16'h0000, mask=0, count=0, full=0, anodes=4'hF, cathodes=8'hFF.
- Enter 1,2,3,4 with switches=1..4 -> numb=16'h1234, mask=4'hF, count=4, full=1. Digit 0 slot: anodes=4'hE, cathodes=8'h99. Digit 3 slot: anodes=4'h7, cathodes=8'hF9.
- While full, enter with switches=A -> numb stays 16'h1234, count stays 4.
- Enter A, then clear+enter together (switches=5) -> numb=0, mask=0, count=0.
- count=1, numb=16'h000C, observe 4 frames -> slot 0 steady cathodes=8'hC6. Slot 1 alternates: 8'hF7 with anode low for 2 frames, then anodes all 1 for 2 frames. Slots 2 and 3 are blank.
- error=1 with numb=16'h1234 -> every slot shows cathodes=8'hBF in blink phase 1 and anodes=4'hF in phase 0. Deassert error -> 1234 shown again from the next digit slot. Assert rst mid-frame -> reset values immediately.
